// File: rtl/mac_cluster_pipe_if.sv
// mac_cluster_pipe_if: beat input, result output and status bundle for mac_cluster_pipe
interface mac_cluster_pipe_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_LANES   = 64,
   parameter int ACC_WIDTH   = 24,
   parameter int CACHE_DEPTH = 32,
   parameter int AW          = $clog2(CACHE_DEPTH)
);
   logic                              in_valid;
   logic                              in_ready;
   logic [NUM_LANES*DATA_WIDTH-1:0]   in_data;
   logic [NUM_LANES*DATA_WIDTH-1:0]   in_weights;
   logic [AW-1:0]                     in_addr;
   logic                              in_first;
   logic                              in_last;
   logic [DATA_WIDTH-1:0]             in_bias;
   logic                              in_relu;
   logic [4:0]                        in_shift;
   logic                              in_clear;
   logic                              out_valid;
   logic [DATA_WIDTH-1:0]             out_data;
   logic [ACC_WIDTH-1:0]              out_acc;
   logic [AW-1:0]                     out_addr;
   logic                              busy;

   modport slave (
      input  in_valid, in_data, in_weights, in_addr, in_first, in_last,
             in_bias, in_relu, in_shift, in_clear,
      output in_ready, out_valid, out_data, out_acc, out_addr, busy
   );

   modport master (
      output in_valid, in_data, in_weights, in_addr, in_first, in_last,
             in_bias, in_relu, in_shift, in_clear,
      input  in_ready, out_valid, out_data, out_acc, out_addr, busy
   );
endinterface

// File: rtl/mac_cluster_pipe.sv
// mac_cluster_pipe: pipelined dot-product MAC with partial-sum cache; MAC_CLUSTER_SAT_EN selects saturating narrowing
module mac_cluster_pipe #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_LANES   = 64,
   parameter int ACC_WIDTH   = 24,
   parameter int CACHE_DEPTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   mac_cluster_pipe_if.slave  bus
);
   localparam int AW = $clog2(CACHE_DEPTH);
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic {IDLE, CLEAR} state_t;

   typedef struct packed {
      logic [AW-1:0]         addr;
      logic                  first;
      logic                  last;
      logic [DATA_WIDTH-1:0] bias;
      logic                  relu;
      logic [4:0]            shift;
   } ctrl_t;

   state_t                       state_q;
   logic [AW-1:0]                clr_idx_q;
   logic                         busy_q;
   logic                         accept;
   logic                         s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic signed [PW-1:0]         s1_prod_q [NUM_LANES];
   logic signed [PW-1:0]         s1_prod_d [NUM_LANES];
   ctrl_t                        s1_ctrl_q, s1_ctrl_d, s2_ctrl_q, s2_ctrl_d;
   logic signed [ACC_WIDTH-1:0]  s2_sum_q, s2_sum_d;
   logic signed [ACC_WIDTH-1:0]  base, acc, res;
   logic [DATA_WIDTH-1:0]        narrowed;
   logic [ACC_WIDTH-1:0]         cache_q [CACHE_DEPTH];
   logic [ACC_WIDTH-1:0]         cache_d [CACHE_DEPTH];
   logic                         fire;
   logic                         out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
   logic [ACC_WIDTH-1:0]         out_acc_q, out_acc_d;
   logic [AW-1:0]                out_addr_q, out_addr_d;
`ifdef MAC_CLUSTER_SAT_EN
   logic signed [ACC_WIDTH-1:0]  shifted;
`endif

   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.in_ready  = ~busy_q & ~bus.in_clear;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_addr  = out_addr_q;

   // Clear sweep: zero one cache entry per cycle, ignoring further clear pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         clr_idx_q <= '0;
         busy_q    <= 1'b0;
      end else if (state_q == IDLE) begin
         if (bus.in_clear) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
         end
      end else begin
         clr_idx_q <= clr_idx_q + 1'b1;
         if (clr_idx_q == AW'(CACHE_DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   // S1: per-lane signed products and beat control captured on accept
   always_comb begin
      s1_valid_d = accept;
      for (int i = 0; i < NUM_LANES; i++)
         s1_prod_d[i] = $signed(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]) *
                        $signed(bus.in_weights[i*DATA_WIDTH +: DATA_WIDTH]);
      s1_ctrl_d = '{addr: bus.in_addr, first: bus.in_first, last: bus.in_last,
                    bias: bus.in_bias, relu: bus.in_relu, shift: bus.in_shift};
   end

   // S2 input: sign-extended adder tree over the registered products
   always_comb begin
      s2_sum_d = '0;
      for (int i = 0; i < NUM_LANES; i++)
         s2_sum_d = s2_sum_d + {{(ACC_WIDTH-PW){s1_prod_q[i][PW-1]}}, s1_prod_q[i]};
      s2_valid_d = s1_valid_q;
      s2_ctrl_d  = s1_ctrl_q;
   end

   // S2 combine: add base, then ReLU, shift and narrow for the last beat
   always_comb begin
      base = s2_ctrl_q.first ?
             {{(ACC_WIDTH-DATA_WIDTH){s2_ctrl_q.bias[DATA_WIDTH-1]}}, s2_ctrl_q.bias} :
             cache_q[s2_ctrl_q.addr];
      acc  = s2_sum_q + base;
      res  = (s2_ctrl_q.relu && acc[ACC_WIDTH-1]) ? '0 : acc;
`ifdef MAC_CLUSTER_SAT_EN
      shifted  = res >>> s2_ctrl_q.shift;
      narrowed = (&shifted[ACC_WIDTH-1:DATA_WIDTH-1] || ~|shifted[ACC_WIDTH-1:DATA_WIDTH-1]) ?
                 shifted[DATA_WIDTH-1:0] :
                 shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
      narrowed = DATA_WIDTH'(res >>> s2_ctrl_q.shift);
`endif
   end

   // Cache update: S2 write-back, with the clear sweep taking priority on collision
   always_comb begin
      cache_d = cache_q;
      if (s2_valid_q) cache_d[s2_ctrl_q.addr] = s2_ctrl_q.last ? '0 : acc;
      if (busy_q) cache_d[clr_idx_q] = '0;
   end

   // Result registers: load only when a last beat leaves S2
   always_comb begin
      fire        = s2_valid_q & s2_ctrl_q.last;
      out_valid_d = fire;
      out_data_d  = fire ? narrowed : out_data_q;
      out_acc_d   = fire ? res : out_acc_q;
      out_addr_d  = fire ? s2_ctrl_q.addr : out_addr_q;
   end

   // Pipeline and output state, flushed by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s1_ctrl_q   <= '0;
         s2_ctrl_q   <= '0;
         s2_sum_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_acc_q   <= '0;
         out_addr_q  <= '0;
         for (int i = 0; i < NUM_LANES; i++) s1_prod_q[i] <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         s1_ctrl_q   <= s1_ctrl_d;
         s2_ctrl_q   <= s2_ctrl_d;
         s2_sum_q    <= s2_sum_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_acc_q   <= out_acc_d;
         out_addr_q  <= out_addr_d;
         for (int i = 0; i < NUM_LANES; i++) s1_prod_q[i] <= s1_prod_d[i];
      end
   end

   // Partial-sum cache storage, deliberately not reset
   always_ff @(posedge clk) begin
      cache_q <= cache_d;
   end
endmodule

// File: tb/tb_mac_cluster_pipe.sv
// tb_mac_cluster_pipe: directed self-checking bench for mac_cluster_pipe
module tb_mac_cluster_pipe;
   localparam int NL = 64;

`ifdef MAC_CLUSTER_SAT_EN
   localparam logic [7:0] EXP_D131 = 8'd127;
   localparam logic [7:0] EXP_D256 = 8'd127;
`else
   localparam logic [7:0] EXP_D131 = 8'h83;
   localparam logic [7:0] EXP_D256 = 8'h00;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cnt_a, cnt_b;

   always #5 clk = ~clk;

   mac_cluster_pipe_if bus ();

   mac_cluster_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input logic [7:0] d, input logic [7:0] w, input logic [4:0] addr,
                           input logic first, input logic last, input logic [7:0] bias,
                           input logic relu, input logic [4:0] shift);
      bus.in_valid   = 1'b1;
      bus.in_data    = {NL{d}};
      bus.in_weights = {NL{w}};
      bus.in_addr    = addr;
      bus.in_first   = first;
      bus.in_last    = last;
      bus.in_bias    = bias;
      bus.in_relu    = relu;
      bus.in_shift   = shift;
   endtask

   task automatic drain_two;
      bus.in_valid = 1'b0;
      tick;
      tick;
   endtask

   task automatic do_clear;
      cnt_a = 0;
      cnt_b = 1;
      bus.in_clear = 1'b1;
      #1;
      check("ready_low_on_clear", {31'd0, bus.in_ready}, 32'd0);
      tick;
      bus.in_clear = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy) cnt_a++;
         if (!bus.in_ready) cnt_b++;
         tick;
      end
      check("busy_cycles", cnt_a, 32'd32);
      check("ready_low_cycles", cnt_b, 32'd33);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_weights = '0;
      bus.in_addr = '0;
      bus.in_first = 1'b0;
      bus.in_last = 1'b0;
      bus.in_bias = '0;
      bus.in_relu = 1'b0;
      bus.in_shift = '0;
      bus.in_clear = 1'b0;
      tick;
      tick;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
      check("rst_out_acc", {8'd0, bus.out_acc}, 32'd0);
      check("rst_out_addr", {27'd0, bus.out_addr}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;
      tick;
      do_clear;

      // single beat with bias, latency check
      set_beat(8'd1, 8'd2, 5'd0, 1'b1, 1'b1, 8'd3, 1'b0, 5'd0);
      tick;
      bus.in_valid = 1'b0;
      tick;
      check("lat_not_early", {31'd0, bus.out_valid}, 32'd0);
      tick;
      check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t1_acc", {8'd0, bus.out_acc}, 32'd131);
      check("t1_data", {24'd0, bus.out_data}, {24'd0, EXP_D131});
      tick;
      check("t1_strobe_single", {31'd0, bus.out_valid}, 32'd0);

      // three back-to-back beats to addr 5
      set_beat(8'd1, 8'd1, 5'd5, 1'b1, 1'b0, 8'd0, 1'b0, 5'd0);
      tick;
      set_beat(8'd1, 8'd1, 5'd5, 1'b0, 1'b0, 8'd0, 1'b0, 5'd0);
      check("t2_ready_b2", {31'd0, bus.in_ready}, 32'd1);
      tick;
      set_beat(8'd1, 8'd1, 5'd5, 1'b0, 1'b1, 8'd0, 1'b0, 5'd1);
      tick;
      drain_two;
      check("t2_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t2_acc", {8'd0, bus.out_acc}, 32'd192);
      check("t2_data", {24'd0, bus.out_data}, 32'd96);
      check("t2_addr", {27'd0, bus.out_addr}, 32'd5);
      set_beat(8'd0, 8'd1, 5'd5, 1'b0, 1'b1, 8'd0, 1'b0, 5'd0);
      tick;
      drain_two;
      check("t2_entry_zeroed", {8'd0, bus.out_acc}, 32'd0);

      // ReLU on and off with negative sum
      set_beat(8'hFF, 8'd1, 5'd7, 1'b1, 1'b1, 8'd0, 1'b1, 5'd0);
      tick;
      set_beat(8'hFF, 8'd1, 5'd8, 1'b1, 1'b1, 8'd0, 1'b0, 5'd0);
      tick;
      bus.in_valid = 1'b0;
      tick;
      check("t3_relu_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t3_relu_acc", {8'd0, bus.out_acc}, 32'd0);
      check("t3_relu_data", {24'd0, bus.out_data}, 32'd0);
      tick;
      check("t3_neg_acc", {8'd0, bus.out_acc}, 32'h00FF_FFC0);
      check("t3_neg_data", {24'd0, bus.out_data}, 32'h0000_00C0);
      check("t3_neg_addr", {27'd0, bus.out_addr}, 32'd8);

      // partial sum wiped by clear sweep
      set_beat(8'd1, 8'd1, 5'd3, 1'b1, 1'b0, 8'd0, 1'b0, 5'd0);
      tick;
      drain_two;
      do_clear;
      set_beat(8'd0, 8'd1, 5'd3, 1'b0, 1'b1, 8'd0, 1'b0, 5'd0);
      tick;
      drain_two;
      check("t4_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t4_acc_cleared", {8'd0, bus.out_acc}, 32'd0);

      // interleaved addrs 0/1, four beats each
      cnt_a = 0;
      for (int i = 0; i < 8; i++) begin
         set_beat(8'd1, 8'd1, 5'(i % 2), i < 2, i >= 6, 8'd0, 1'b0, 5'd0);
         if (!bus.in_ready) cnt_a++;
         tick;
      end
      check("t5_no_stall", cnt_a, 32'd0);
      bus.in_valid = 1'b0;
      tick;
      check("t5_r0_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t5_r0_acc", {8'd0, bus.out_acc}, 32'd256);
      check("t5_r0_data", {24'd0, bus.out_data}, {24'd0, EXP_D256});
      check("t5_r0_addr", {27'd0, bus.out_addr}, 32'd0);
      tick;
      check("t5_r1_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t5_r1_acc", {8'd0, bus.out_acc}, 32'd256);
      check("t5_r1_addr", {27'd0, bus.out_addr}, 32'd1);

      // reset with two beats in flight
      set_beat(8'd1, 8'd1, 5'd2, 1'b1, 1'b1, 8'd5, 1'b0, 5'd0);
      tick;
      tick;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t6_async_acc", {8'd0, bus.out_acc}, 32'd0);
      tick;
      rst_n = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.out_valid) cnt_a++;
         tick;
      end
      check("t6_no_flushed_valid", cnt_a, 32'd0);
      check("t6_out_acc", {8'd0, bus.out_acc}, 32'd0);
      check("t6_out_data", {24'd0, bus.out_data}, 32'd0);
      check("t6_out_addr", {27'd0, bus.out_addr}, 32'd0);
      check("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mac_cluster_pipe.md
# mac_cluster_pipe

Parametrised, pipelined successor of the 16×MAC4 cluster. Computes an NUM_LANES-wide signed dot product per accepted beat and accumulates it into an internal partial-sum cache entry selected per beat. On the beat marked last, it applies bias, optional ReLU, arithmetic shift and output narrowing, then emits the result. Sits between the PE-array operand buffers and the output writeback path; a valid/ready handshake replaces the old free-running enable.

## Interface
- DATA_WIDTH, 8, signed operand and output width
- NUM_LANES, 64, multipliers per beat (≥1)
- ACC_WIDTH, 24, accumulator/cache word width (≥ 2*DATA_WIDTH + clog2(NUM_LANES) + 1)
- CACHE_DEPTH, 32, partial-sum entries (power of 2, ≥2); AW = clog2(CACHE_DEPTH)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid & in_ready at a rising edge
- in_data  in  NUM_LANES*DATA_WIDTH  signed activations, lane i = bits [i*DW +: DW]
- in_weights  in  NUM_LANES*DATA_WIDTH  signed weights, same packing
- in_addr  in  AW  cache entry for this beat
- in_first  in  1  base = bias instead of cache entry
- in_last  in  1  final beat: emit result, zero the entry
- in_bias  in  DATA_WIDTH  signed bias, used only with in_first
- in_relu  in  1  apply ReLU on last beat
- in_shift  in  5  arithmetic right shift on last beat (values ≥ ACC_WIDTH give sign fill)
- in_clear  in  1  single-cycle pulse: zero entire cache
- out_valid  out  1  single-cycle result strobe
- out_data  out  DATA_WIDTH  narrowed result
- out_acc  out  ACC_WIDTH  post-ReLU, pre-shift accumulator
- out_addr  out  AW  entry that produced the result
- busy  out  1  clear sweep in progress

## Operation
- Stage 1 (S1): on accept, register NUM_LANES signed products (2*DW bits each), plus addr/first/last/bias/relu/shift.
- Stage 2 (S2): sign-extended adder tree to ACC_WIDTH; base = sign-extended bias if first, else cache[addr]; acc = tree + base. Arithmetic wraps modulo 2^ACC_WIDTH.
- End of S2, not last: cache[addr] ← acc.
- End of S2, last: cache[addr] ← 0; r = relu & acc<0 ? 0 : acc; out_acc ← r; out_data ← narrow(r >>> shift); out_addr ← addr; out_valid ← 1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR when in_clear is sampled high.
  - CLEAR writes 0 to one entry per cycle, index 0..CACHE_DEPTH-1; returns to IDLE after the last index.
  - in_ready = (state==IDLE) & ~in_clear; busy = (state==CLEAR).
- Beats already in S1/S2 when clear is sampled complete normally; their out_valid is still emitted, and their cache writes are overwritten by the sweep.
- in_clear during CLEAR: ignored.
- Cache contents are not reset by rst_n; software issues in_clear after reset.

## Timing
- Latency: beat accepted at edge T → S2 result registered at edge T+2; out_valid high in the cycle after T+2.
- Throughput: 1 beat/cycle while in_ready.
- Back-to-back beats to the same addr need no bubble: S2 reads the cache during the cycle after the previous write edge, so it sees the updated value.
- Clear sweep occupies exactly CACHE_DEPTH cycles; in_ready is low for CACHE_DEPTH+1 cycles, counting the in_clear cycle.
- Reset values: out_valid 0, out_data 0, out_acc 0, out_addr 0, busy 0, FSM IDLE, S1/S2 valid bits 0, in_ready 1.
- Reset mid-operation flushes the pipeline; no out_valid is produced for flushed beats.

## Configuration
- MAC_CLUSTER_SAT_EN defined: narrow() saturates to [-2^(DW-1), 2^(DW-1)-1].
- MAC_CLUSTER_SAT_EN undefined: narrow() keeps the low DATA_WIDTH bits (two's-complement wrap).

## Test plan
- Defaults; all lanes data=1, weight=2, first+last, bias=3, shift=0, relu=0 → out_acc=131; out_data=127 with SAT_EN, 0x83 (-125) without; out_valid 2 cycles after accept.
- Three consecutive beats to addr 5, data=1, weight=1; first on beat 1 (bias 0), last on beat 3, shift=1 → out_acc=192, out_data=96, out_addr=5; cache[5] reads 0 afterwards.
- data=-1, weight=1, first+last, bias=0 → relu=1 gives out_acc=0, out_data=0; relu=0 gives out_acc=-64, out_data=-64.
- Non-last beat leaves 64 in addr 3; pulse in_clear → busy high 32 cycles, in_ready low 33; then beat to addr 3 with first=0, last=1, data=0 → out_acc=0.
- Interleave addrs 0/1 on alternating cycles, 4 beats each, data=1, weight=1 → two results of 256 (out_data 127 saturated), correct out_addr per result, no stalls.
- Drop rst_n with two beats in flight → out_valid stays 0, outputs zero, in_ready=1 after release.
